// File: rtl/step_motor_pkg.sv
// Shared definitions for the stepper-motor sequencer.
//   state_e          : sequencer FSM states
//   RATE_*           : selectable step rates in steps/s
//   HALF_STEP_TABLE  : coil drive {D,C,B,A} for each of the 8 half-step phases
//   step_period()    : clock cycles per step for a clock frequency and speed_sel
//   next_index()     : phase index after one step in the given direction/mode
package step_motor_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned RATE_SLOW = 50;
  localparam int unsigned RATE_MED  = 100;
  localparam int unsigned RATE_FAST = 200;
  localparam int unsigned RATE_MAX  = 400;

  // Entry i sits at bits [4*i+3:4*i]; index 0 is the least significant nibble.
  localparam logic [7:0][3:0] HALF_STEP_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  function automatic int unsigned step_period(input int unsigned clk_hz,
                                              input logic [1:0]  sel);
    int unsigned rate;
    case (sel)
      2'd0:    rate = RATE_SLOW;
      2'd1:    rate = RATE_MED;
      2'd2:    rate = RATE_FAST;
      default: rate = RATE_MAX;
    endcase
    return clk_hz / rate;
  endfunction

  // Full steps from an odd (two-coil) phase jump two entries; from an even
  // (single-coil) phase they move one entry so the motor lands on an odd phase.
  function automatic logic [2:0] next_index(input logic [2:0] idx,
                                            input logic       fwd,
                                            input logic       full);
    logic [2:0] delta;
    delta = (full && idx[0]) ? 3'd2 : 3'd1;
    return fwd ? idx + delta : idx - delta;
  endfunction

endpackage

// File: rtl/step_rate_timer.sv
// Step period timer: counts 0..period-1 and wraps, raising tc on the last count.
//   clk, reset  : clock and synchronous active-high reset
//   load        : capture period_in as the period for the next count cycle
//   period_in   : new period in clock cycles
//   run         : count while high, held at 0 while low
//   clear       : force the count to 0 and suppress tc this cycle
//   tc          : terminal-count strobe (combinational, one cycle per period)
module step_rate_timer #(
  parameter int unsigned      WIDTH        = 8,
  parameter logic [WIDTH-1:0] RESET_PERIOD = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] period_in,
  input  logic             run,
  input  logic             clear,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;

  assign tc = run && !clear && (count_q == period_q - 1'b1);

  always_comb begin
    count_d  = count_q + 1'b1;
    if (!run || clear || tc) begin
      count_d = '0;
    end
    period_d = load ? period_in : period_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      period_q <= RESET_PERIOD;
    end else begin
      count_q  <= count_d;
      period_q <= period_d;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Stepper-motor phase sequencer: steps a 4-coil motor at a selectable rate
// while motion is requested.
//   clk, reset      : clock and synchronous active-high reset
//   sw2_enabled     : continuous motion request
//   quarter_active  : quarter-rotation-in-progress request
//   direction       : 1 = forward (phase index increments), 0 = reverse
//   step_size       : 1 = full step, 0 = half step
//   speed_sel       : 0/1/2/3 = 50/100/200/400 steps/s
//   coil            : phase drive {D,C,B,A}
//   step_pulse      : one-cycle strobe per step taken
//   moving          : high while running
module step_sequencer
  import step_motor_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned HOLD_TORQUE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw2_enabled,
  input  logic       quarter_active,
  input  logic       direction,
  input  logic       step_size,
  input  logic [1:0] speed_sel,
  output logic [3:0] coil,
  output logic       step_pulse,
  output logic       moving
);

  localparam int unsigned    TW         = $clog2(CLK_FREQ_HZ / RATE_SLOW + 1);
  localparam logic [TW-1:0]  P_RESET    = TW'(step_period(CLK_FREQ_HZ, 2'd0));
  localparam logic [3:0]     COIL_RESET = (HOLD_TORQUE != 0) ? HALF_STEP_TABLE[0] : 4'b0000;

  state_e     state_q, state_d;
  logic [2:0] index_q, index_d;
  logic       step_pulse_q, step_pulse_d;
  logic       moving_q, moving_d;
  logic [3:0] coil_q, coil_d;

  logic          enable;
  logic          tc;
  logic          load;
  logic [TW-1:0] period_in;

  assign enable    = sw2_enabled | quarter_active;
  assign period_in = TW'(step_period(CLK_FREQ_HZ, speed_sel));
  assign load      = enable && ((state_q == ST_IDLE) || tc);

  // clear = ~enable makes a falling request win over a coincident terminal count.
  step_rate_timer #(
    .WIDTH        (TW),
    .RESET_PERIOD (P_RESET)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .period_in (period_in),
    .run       (state_q == ST_RUN),
    .clear     (!enable),
    .tc        (tc)
  );

  always_comb begin
    state_d      = enable ? ST_RUN : ST_IDLE;
    step_pulse_d = tc;
    index_d      = tc ? next_index(index_q, direction, step_size) : index_q;
    moving_d     = (state_d == ST_RUN);
    // Coil follows the current index, so a new phase appears the cycle after the step.
    coil_d       = '0;
    if ((state_d == ST_RUN) || (HOLD_TORQUE != 0)) begin
      coil_d = HALF_STEP_TABLE[index_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      index_q      <= '0;
      step_pulse_q <= 1'b0;
      moving_q     <= 1'b0;
      coil_q       <= COIL_RESET;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      step_pulse_q <= step_pulse_d;
      moving_q     <= moving_d;
      coil_q       <= coil_d;
    end
  end

  assign coil       = coil_q;
  assign step_pulse = step_pulse_q;
  assign moving     = moving_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer at CLK_FREQ_HZ=8000 (periods 160/80/40/20), with
// one holding-torque and one free-wheeling instance on shared inputs.
module tb_step_sequencer;

  localparam int unsigned CLK_HZ = 8000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sw2_enabled = 1'b0;
  logic       quarter_active = 1'b0;
  logic       direction = 1'b1;
  logic       step_size = 1'b0;
  logic [1:0] speed_sel = 2'd0;

  logic [3:0] coil_h, coil_n;
  logic       pulse_h, pulse_n, moving_h, moving_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  step_sequencer #(.CLK_FREQ_HZ(CLK_HZ), .HOLD_TORQUE(1)) dut_h (
    .clk(clk), .reset(reset), .sw2_enabled(sw2_enabled),
    .quarter_active(quarter_active), .direction(direction),
    .step_size(step_size), .speed_sel(speed_sel),
    .coil(coil_h), .step_pulse(pulse_h), .moving(moving_h)
  );

  step_sequencer #(.CLK_FREQ_HZ(CLK_HZ), .HOLD_TORQUE(0)) dut_n (
    .clk(clk), .reset(reset), .sw2_enabled(sw2_enabled),
    .quarter_active(quarter_active), .direction(direction),
    .step_size(step_size), .speed_sel(speed_sel),
    .coil(coil_n), .step_pulse(pulse_n), .moving(moving_n)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [3:0]  tbl   [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                             4'b0100, 4'b1100, 4'b1000, 4'b1001};
  int unsigned rates [4] = '{50, 100, 200, 400};

  bit          m_valid = 0;
  bit          m_run = 0;
  bit          m_pulse = 0;
  int unsigned m_elapsed = 0;
  int unsigned m_per = 0;
  int unsigned m_idx = 0;
  int unsigned m_old_idx = 0;
  int unsigned m_stride = 1;
  logic [3:0]  m_coil_h = 4'b0001;
  logic [3:0]  m_coil_n = 4'b0000;

  always @(posedge clk) begin
    if (reset) begin
      m_valid  = 1;
      m_run    = 0;
      m_pulse  = 0;
      m_elapsed = 0;
      m_idx    = 0;
      m_coil_h = tbl[0];
      m_coil_n = 4'b0000;
    end else begin
      m_old_idx = m_idx;
      m_pulse   = 0;
      if (!m_run) begin
        if (sw2_enabled || quarter_active) begin
          m_run     = 1;
          m_elapsed = 0;
          m_per     = CLK_HZ / rates[speed_sel];
        end
      end else if (!(sw2_enabled || quarter_active)) begin
        m_run     = 0;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_per) begin
          m_pulse   = 1;
          m_elapsed = 0;
          m_per     = CLK_HZ / rates[speed_sel];
          m_stride  = (step_size && (m_idx % 2 == 1)) ? 2 : 1;
          m_idx     = direction ? (m_idx + m_stride) % 8 : (m_idx + 8 - m_stride) % 8;
        end
      end
      m_coil_h = tbl[m_old_idx];
      m_coil_n = m_run ? tbl[m_old_idx] : 4'b0000;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("pulse_h",  pulse_h,  m_pulse);
      chk("pulse_n",  pulse_n,  m_pulse);
      chk("moving_h", moving_h, m_run);
      chk("moving_n", moving_n, m_run);
      chk("coil_h",   coil_h,   m_coil_h);
      chk("coil_n",   coil_n,   m_coil_n);
    end
  end

  // ---------------- stimulus + literal expectations ----------------
  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_pulse(input int max_cyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!pulse_h && cyc < max_cyc);
    if (!pulse_h) chk("wait_pulse_timeout", 0, 1);
  endtask

  logic [3:0] full_exp [7] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001,
                               4'b0011, 4'b1001, 4'b1100};
  logic [3:0] prev_coil;
  int cyc;
  int cnt;
  int extra;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_coil_h", coil_h, 4'b0001);
    chk("rst_coil_n", coil_n, 4'b0000);
    chk("rst_pulse", pulse_h, 0);
    chk("rst_moving", moving_h, 0);

    // half step forward at 400 steps/s
    reset = 1'b0; sw2_enabled = 1'b1; speed_sel = 2'd3; direction = 1'b1; step_size = 1'b0;
    @(negedge clk);
    chk("run_entry_moving", moving_h, 1);
    for (int n = 1; n <= 61; n++) begin
      @(negedge clk);
      chk("half_pulse_timing", pulse_h, (n % 20 == 0) ? 1 : 0);
      if (n == 21) chk("half_coil_1", coil_h, 4'b0011);
      if (n == 41) chk("half_coil_2", coil_h, 4'b0010);
      if (n == 61) chk("half_coil_3", coil_h, 4'b0110);
    end
    sw2_enabled = 1'b0;
    @(negedge clk);
    chk("idle_moving", moving_h, 0);
    chk("idle_hold_coil", coil_h, 4'b0110);
    chk("idle_free_coil", coil_n, 4'b0000);

    // full step forward from index 0, then reverse from index 1
    do_reset();
    sw2_enabled = 1'b1; step_size = 1'b1; direction = 1'b1; speed_sel = 2'd3;
    for (int k = 0; k < 7; k++) begin
      wait_pulse(100, cyc);
      @(negedge clk);
      chk("full_step_coil", coil_h, full_exp[k]);
      if (k == 4) direction = 1'b0;
    end

    // disable coincident with terminal count
    wait_pulse(100, cyc);
    repeat (19) @(negedge clk);
    prev_coil = coil_h;
    sw2_enabled = 1'b0;
    @(negedge clk);
    chk("tie_pulse", pulse_h, 0);
    chk("tie_moving", moving_h, 0);
    chk("tie_coil", coil_h, prev_coil);
    @(negedge clk);
    chk("tie_coil_after", coil_h, prev_coil);

    // speed change mid-period
    do_reset();
    speed_sel = 2'd0; step_size = 1'b0; direction = 1'b1; sw2_enabled = 1'b1;
    @(negedge clk);
    repeat (50) @(negedge clk);
    speed_sel = 2'd3;
    wait_pulse(300, cyc);
    chk("speed_change_first", cyc, 110);
    wait_pulse(300, cyc);
    chk("speed_change_next", cyc, 20);
    sw2_enabled = 1'b0;
    @(negedge clk);

    // quarter rotation: external counter stops after 50 pulses
    step_size = 1'b1; speed_sel = 2'd3; quarter_active = 1'b1;
    cyc = 0; cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      cyc++;
      if (pulse_h) cnt++;
      if (cnt == 50) break;
    end
    quarter_active = 1'b0;
    chk("quarter_pulses", cnt, 50);
    chk("quarter_cycles", cyc, 1001);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pulse_h) extra++;
    end
    chk("quarter_extra", extra, 0);
    chk("quarter_idle", moving_h, 0);
    chk("quarter_free_coil", coil_n, 4'b0000);

    // reset in the middle of a period
    sw2_enabled = 1'b1; speed_sel = 2'd3;
    @(negedge clk);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_pulse", pulse_h, 0);
    chk("midrst_moving", moving_h, 0);
    chk("midrst_coil_h", coil_h, 4'b0001);
    chk("midrst_coil_n", coil_n, 4'b0000);
    reset = 1'b0; sw2_enabled = 1'b0;

    // randomized traffic
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) sw2_enabled = ~sw2_enabled;
      if ($urandom_range(0, 79) == 0) quarter_active = ~quarter_active;
      if ($urandom_range(0, 29) == 0) speed_sel = 2'($urandom_range(0, 3));
      direction = 1'($urandom_range(0, 1));
      step_size = 1'($urandom_range(0, 1));
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 The module SHALL have parameter CLK_FREQ_HZ, default 50_000_000, meaning the clk frequency in Hz used to derive step periods.
REQ-002 The module SHALL have parameter HOLD_TORQUE, default 1, meaning 1 = coils stay energized while idle and 0 = coils are de-energized while idle.
REQ-003 The module SHALL have port clk, input, 1 bit, the system clock; the block uses a single clock domain.
REQ-004 The module SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The module SHALL have port sw2_enabled, input, 1 bit, the continuous motion request.
REQ-006 The module SHALL have port quarter_active, input, 1 bit, the quarter-rotation-in-progress request.
REQ-007 The module SHALL have port direction, input, 1 bit, where 1 = forward (phase index increments) and 0 = reverse.
REQ-008 The module SHALL have port step_size, input, 1 bit, where 1 = full step (1.8°) and 0 = half step (0.9°).
REQ-009 The module SHALL have port speed_sel, input, 2 bits, selecting 50, 100, 200 or 400 steps/s for values 0, 1, 2 and 3.
REQ-010 The module SHALL have port coil, output, 4 bits, the motor phase drive {D,C,B,A}.
REQ-011 The module SHALL have port step_pulse, output, 1 bit, a one-cycle strobe per step taken.
REQ-012 The module SHALL have port moving, output, 1 bit, high while in the RUN state.

Function
REQ-013 The FSM SHALL have two states: IDLE and RUN; enable = sw2_enabled | quarter_active.
REQ-014 IDLE→RUN SHALL occur on the first clk where enable=1; RUN→IDLE SHALL occur on the first clk where enable=0.
REQ-015 In RUN, the period timer SHALL count 0..P-1 and wrap, with P = CLK_FREQ_HZ / rate(speed_sel) using integer division.
REQ-016 P SHALL be latched on entry to RUN and at each wrap; a speed_sel change mid-period SHALL NOT alter the current period.
REQ-017 The first step SHALL occur exactly P clocks after the IDLE→RUN transition; subsequent steps SHALL occur every P clocks.
REQ-018 At each step event: step_pulse=1 for exactly one cycle, and the 3-bit phase index SHALL update in the same cycle, with coil reflecting the new index the following cycle.
REQ-019 Half-step table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
REQ-020 Half step SHALL move the index ±1 mod 8.
REQ-021 Full step SHALL move the index ±2 mod 8 when the index is odd (two-phase-on).
REQ-022 Full step SHALL move the index ±1 when the index is even, realigning it onto an odd index.
REQ-023 direction and step_size SHALL be sampled only at step events.
REQ-024 If enable falls in the same cycle the timer reaches P-1, the disable SHALL win: no step_pulse and no index change.
REQ-025 In IDLE, the timer SHALL be held at 0, step_pulse=0 and the index SHALL be retained.
REQ-026 In IDLE, coil SHALL equal table[index] if HOLD_TORQUE=1, else 4'b0000.
REQ-027 In RUN, coil SHALL always equal table[index].
REQ-028 moving SHALL be registered and equal (state==RUN).

Reset
REQ-029 Reset SHALL be synchronous and active-high, and SHALL take priority over all other inputs.
REQ-030 On reset: state=IDLE, timer=0, index=0, P=period(50 steps/s), step_pulse=0, moving=0.
REQ-031 On reset, coil SHALL be 4'b0001 if HOLD_TORQUE=1, else 4'b0000.
REQ-032 Reset asserted mid-RUN SHALL abort the motion on the next edge with no step_pulse emitted.

Structure
REQ-033 Package step_motor_pkg SHALL hold the state enum, the rate constants (50/100/200/400), the 8-entry half-step table, and a period function of (CLK_FREQ_HZ, speed_sel).
REQ-034 The timer SHALL be sub-module step_rate_timer (inputs: load period, run, clear; output: terminal-count strobe), and its width SHALL be sized from CLK_FREQ_HZ/50.
REQ-035 step_pulse SHALL be compatible with the existing quarter-rotation counter: exactly one pulse per mechanical step.

Verification (CLK_FREQ_HZ=8000 → P=160/80/40/20)
REQ-036 Test: reset, sw2_enabled=1, speed_sel=3, half, forward → step_pulse at clocks 20, 40, 60…; coil runs 0011, 0010, 0110….
REQ-037 Test: from index 0, full step forward → index goes 1, 3, 5, 7, 1; reverse from 1 → 7, 5.
REQ-038 Test: enable drops on the same cycle the timer reaches 19 → no pulse, index unchanged, moving=0 next cycle.
REQ-039 Test: speed_sel changes 0→3 at timer=50 → current step completes at 160, and the next step comes 20 clocks later.
REQ-040 Test: quarter_active pulse sequence with full step → exactly 50 step_pulses, then IDLE; with HOLD_TORQUE=0, coil=0000 in IDLE.
REQ-041 Test: reset asserted at timer=10 in RUN → all outputs return to reset values on the next edge, with no pulse.
